// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle 16-bit processor control FSM: opcodes, ALUOp,
// state encodings, datapath select encodings and the decoded control word.
package ctrl_pkg;

    localparam int OPW_C  = 4;
    localparam int ST_W_C = 4;

    localparam logic [OPW_C-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OPW_C-1:0] OP_LW    = 4'b0001;
    localparam logic [OPW_C-1:0] OP_SW    = 4'b0010;
    localparam logic [OPW_C-1:0] OP_BEQ   = 4'b0011;
    localparam logic [OPW_C-1:0] OP_J     = 4'b0100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_TWO    = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [ST_W_C-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ILLEGAL  = 4'd10
    } state_e;

    // gate_rdy: pc_write, ir_write and instr_done of this state wait for mem_ready
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
        logic       gate_rdy;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/flags/mem_ready in, mux selects and strobes out.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int OPW = 4
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic           pc_write;
    logic           pc_write_cond;
    logic           i_or_d;
    logic           mem_read;
    logic           mem_write;
    logic           ir_write;
    logic           mem_to_reg;
    logic           reg_dst;
    logic           reg_write;
    logic           alu_src_a;
    logic [1:0]     alu_src_b;
    logic [1:0]     alu_op;
    logic [1:0]     pc_source;
    logic           instr_done;
    logic           illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational Moore decode of FSM state into the datapath control word (zero latency).
// ILLEGAL is a sticky trap when CTRL_ILLEGAL_TRAP_EN is defined, otherwise a one-cycle NOP.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_e     state_i,
    output ctrl_word_t word_o
);

    always_comb begin
        word_o = '0;
        case (state_i)
            S_FETCH: begin
                word_o.mem_read  = 1'b1;
                word_o.alu_src_b = ASB_TWO;
                word_o.alu_op    = ALUOP_ADD;
                word_o.pc_source = PCS_ALU;
                word_o.ir_write  = 1'b1;
                word_o.pc_write  = 1'b1;
                word_o.gate_rdy  = 1'b1;
            end
            S_DECODE: begin
                // branch target precomputed into ALUOut
                word_o.alu_src_b = ASB_IMM_SH;
                word_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADDR: begin
                word_o.alu_src_a = 1'b1;
                word_o.alu_src_b = ASB_IMM;
                word_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                word_o.mem_read = 1'b1;
                word_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                word_o.reg_write  = 1'b1;
                word_o.mem_to_reg = 1'b1;
                word_o.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                word_o.mem_write  = 1'b1;
                word_o.i_or_d     = 1'b1;
                word_o.instr_done = 1'b1;
                word_o.gate_rdy   = 1'b1;
            end
            S_EXEC: begin
                word_o.alu_src_a = 1'b1;
                word_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                word_o.reg_write  = 1'b1;
                word_o.reg_dst    = 1'b1;
                word_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                word_o.alu_src_a     = 1'b1;
                word_o.alu_op        = ALUOP_SUB;
                word_o.pc_write_cond = 1'b1;
                word_o.pc_source     = PCS_ALUOUT;
                word_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                word_o.pc_write   = 1'b1;
                word_o.pc_source  = PCS_JUMP;
                word_o.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                word_o.illegal    = 1'b1;
`else
                word_o.instr_done = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: one instruction per trip, 3-5 cycles plus one per mem_ready-low wait.
// Memory states stall on mem_ready; ILLEGAL traps when CTRL_ILLEGAL_TRAP_EN is defined.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPW  = OPW_C,
    parameter int ST_W = ST_W_C
) (
    input  logic               clock,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    state_e          cur_s;
    state_e          nxt_s;
    ctrl_word_t      w;
    logic            rdy_ok;

    assign cur_s   = state_e'(state_q);
    assign state_d = ST_W'(nxt_s);

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_W'(S_FETCH);
        else       state_q <= state_d;
    end

    always_comb begin
        nxt_s = S_FETCH;
        case (cur_s)
            S_FETCH:    nxt_s = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if      (bus.opcode == OPW'(OP_RTYPE)) nxt_s = S_EXEC;
                else if (bus.opcode == OPW'(OP_LW) ||
                         bus.opcode == OPW'(OP_SW))    nxt_s = S_MEMADDR;
                else if (bus.opcode == OPW'(OP_BEQ))   nxt_s = S_BRANCH;
                else if (bus.opcode == OPW'(OP_J))     nxt_s = S_JUMP;
                else                                   nxt_s = S_ILLEGAL;
            end
            S_MEMADDR:  nxt_s = (bus.opcode == OPW'(OP_LW)) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt_s = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    nxt_s = S_FETCH;
            S_MEMWRITE: nxt_s = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXEC:     nxt_s = S_RWB;
            S_RWB:      nxt_s = S_FETCH;
            S_BRANCH:   nxt_s = S_FETCH;
            S_JUMP:     nxt_s = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  nxt_s = S_ILLEGAL;
`else
            S_ILLEGAL:  nxt_s = S_FETCH;
`endif
            default:    nxt_s = S_FETCH;
        endcase
    end

    ctrl_out_decode u_dec (
        .state_i (cur_s),
        .word_o  (w)
    );

    // every output is forced low while reset is held, including the mid-access case
    assign rdy_ok            = !w.gate_rdy || bus.mem_ready;
    assign bus.pc_write      = !reset && ((w.pc_write && rdy_ok) || (w.pc_write_cond && bus.zero));
    assign bus.pc_write_cond = !reset && w.pc_write_cond;
    assign bus.i_or_d        = !reset && w.i_or_d;
    assign bus.mem_read      = !reset && w.mem_read;
    assign bus.mem_write     = !reset && w.mem_write;
    assign bus.ir_write      = !reset && w.ir_write && rdy_ok;
    assign bus.mem_to_reg    = !reset && w.mem_to_reg;
    assign bus.reg_dst       = !reset && w.reg_dst;
    assign bus.reg_write     = !reset && w.reg_write;
    assign bus.alu_src_a     = !reset && w.alu_src_a;
    assign bus.alu_src_b     = reset ? 2'b00 : w.alu_src_b;
    assign bus.alu_op        = reset ? 2'b00 : w.alu_op;
    assign bus.pc_source     = reset ? 2'b00 : w.pc_source;
    assign bus.instr_done    = !reset && w.instr_done && rdy_ok;
    assign bus.illegal       = !reset && w.illegal;

endmodule
